// File: rtl/traffic_pkg.sv
// Light-head codes, fault codes and code-class helpers shared by the traffic controller and its monitor.
package traffic_pkg;

    localparam logic [2:0] GREEN     = 3'b110;
    localparam logic [2:0] YELLOW    = 3'b101;
    localparam logic [2:0] RED_CLEAR = 3'b100;
    localparam logic [2:0] RED_A     = 3'b011;
    localparam logic [2:0] RED_B     = 3'b010;
    localparam logic [2:0] RED_WALK  = 3'b111;
    localparam logic [2:0] DARK      = 3'b000;
    localparam logic [2:0] ILLEGAL   = 3'b001;

    // Numeric order is also the reporting priority: lower code wins.
    typedef enum logic [2:0] {
        NONE        = 3'd0,
        CONFLICT    = 3'd1,
        WALK_UNSAFE = 3'd2,
        BAD_CODE    = 3'd3,
        BAD_SEQ     = 3'd4,
        SHORT_PHASE = 3'd5,
        STALL       = 3'd6
    } fault_e;

    function automatic logic is_red_class(input logic [2:0] code);
        return (code == RED_A) || (code == RED_B) || (code == RED_CLEAR) || (code == RED_WALK);
    endfunction

    function automatic logic is_go(input logic [2:0] code);
        return (code == GREEN) || (code == YELLOW);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating dwell counter: loads 1 on restart, otherwise counts up and sticks at all-ones.
module dwell_counter #(
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_restart,
    output logic [CW-1:0] o_cnt
);

    localparam logic [CW-1:0] SAT = '1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= {{(CW-1){1'b0}}, 1'b1};
        end else if (r_cnt != SAT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_monitor.sv
// Safety monitor for the two-approach controller: checks head/walk outputs every cycle and latches the first fault.
// One registered stage from a sampled violation to ERR/fault; no combinational input-to-output path.
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 3,
    parameter int MIN_WALK   = 6,
    parameter int MAX_DWELL  = 64,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] LA,
    input  logic [2:0] LB,
    input  logic       RA,
    input  logic       RB,
    input  logic       clr,
    output logic       ERR,
    output logic [2:0] fault
);

    localparam logic [CW-1:0] L_MIN_GREEN  = CW'(MIN_GREEN);
    localparam logic [CW-1:0] L_MIN_YELLOW = CW'(MIN_YELLOW);
    localparam logic [CW-1:0] L_MIN_WALK   = CW'(MIN_WALK);
    // The unchanged current sample extends the stored run by one.
    localparam logic [CW-1:0] L_STALL_AT   = CW'(MAX_DWELL - 1);

    logic [2:0]    r_prev_la;
    logic [2:0]    r_prev_lb;
    logic          r_prev_ra;
    logic          r_prev_rb;
    logic          r_seen;
    logic          r_armed;
    logic          r_err;
    fault_e        r_fault;

    logic          w_chg_la;
    logic          w_chg_lb;
    logic          w_chg_ra;
    logic          w_chg_any;
    logic [CW-1:0] w_cnt_la;
    logic [CW-1:0] w_cnt_lb;
    logic [CW-1:0] w_cnt_wk;
    logic [CW-1:0] w_cnt_gl;
    logic          w_conflict;
    logic          w_walk_unsafe;
    logic          w_bad_code;
    logic          w_bad_seq;
    logic          w_short;
    logic          w_stall;
    fault_e        w_code;

    function automatic logic f_bad_seq(input logic [2:0] p, input logic [2:0] c);
        logic bad;
        bad = 1'b0;
        if (c != p) begin
            if ((c == GREEN) && !is_red_class(p)) bad = 1'b1;
            if ((p == GREEN) && (c != YELLOW)) bad = 1'b1;
            if ((p == YELLOW) && (c != RED_CLEAR) && (c != RED_A) && (c != RED_B)) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic f_short(input logic [2:0] p, input logic [2:0] c, input logic [CW-1:0] d);
        return (c != p) && (((p == GREEN) && (d < L_MIN_GREEN)) || ((p == YELLOW) && (d < L_MIN_YELLOW)));
    endfunction

    assign w_chg_la  = (LA != r_prev_la);
    assign w_chg_lb  = (LB != r_prev_lb);
    assign w_chg_ra  = (RA != r_prev_ra);
    assign w_chg_any = w_chg_la || w_chg_lb || w_chg_ra || (RB != r_prev_rb);

    dwell_counter #(.CW(CW)) u_dwell_la (
        .i_clk(clk), .i_rst(reset), .i_restart(clr || w_chg_la), .o_cnt(w_cnt_la)
    );
    dwell_counter #(.CW(CW)) u_dwell_lb (
        .i_clk(clk), .i_rst(reset), .i_restart(clr || w_chg_lb), .o_cnt(w_cnt_lb)
    );
    dwell_counter #(.CW(CW)) u_dwell_walk (
        .i_clk(clk), .i_rst(reset), .i_restart(clr || w_chg_ra), .o_cnt(w_cnt_wk)
    );
    dwell_counter #(.CW(CW)) u_dwell_glob (
        .i_clk(clk), .i_rst(reset), .i_restart(clr || w_chg_any), .o_cnt(w_cnt_gl)
    );

    assign w_conflict    = is_go(LA) && is_go(LB);
    assign w_walk_unsafe = ((RA || RB) && !((LA == RED_WALK) && (LB == RED_WALK))) || (RA != RB);
    assign w_bad_code    = (LA == ILLEGAL) || (LB == ILLEGAL) || ((LA == DARK) != (LB == DARK));
    assign w_bad_seq     = r_armed && (f_bad_seq(r_prev_la, LA) || f_bad_seq(r_prev_lb, LB));
    assign w_short       = r_armed && (f_short(r_prev_la, LA, w_cnt_la) || f_short(r_prev_lb, LB, w_cnt_lb)
                                       || (r_prev_ra && !RA && (w_cnt_wk < L_MIN_WALK)));
    assign w_stall       = r_armed && !w_chg_any && (w_cnt_gl >= L_STALL_AT)
                           && !((LA == DARK) && (LB == DARK));

    always_comb begin
        w_code = NONE;
        if (!clr) begin
            if (w_conflict)         w_code = CONFLICT;
            else if (w_walk_unsafe) w_code = WALK_UNSAFE;
            else if (w_bad_code)    w_code = BAD_CODE;
            else if (w_bad_seq)     w_code = BAD_SEQ;
            else if (w_short)       w_code = SHORT_PHASE;
            else if (w_stall)       w_code = STALL;
        end
    end

    // r_seen keeps the reset value of the prev registers from looking like a change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_la <= DARK;
            r_prev_lb <= DARK;
            r_prev_ra <= 1'b0;
            r_prev_rb <= 1'b0;
            r_seen    <= 1'b0;
            r_armed   <= 1'b0;
            r_err     <= 1'b0;
            r_fault   <= NONE;
        end else begin
            r_prev_la <= LA;
            r_prev_lb <= LB;
            r_prev_ra <= RA;
            r_prev_rb <= RB;
            r_seen    <= 1'b1;
            if (clr) begin
                r_armed <= 1'b0;
                r_err   <= 1'b0;
                r_fault <= NONE;
            end else begin
                if (r_seen && (w_chg_la || w_chg_lb)) r_armed <= 1'b1;
                if (!r_err && (w_code != NONE)) begin
                    r_err   <= 1'b1;
                    r_fault <= w_code;
                end
            end
        end
    end

    assign ERR   = r_err;
    assign fault = r_fault;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed and randomized bench for traffic_monitor against a history-based reference model.
module tb_traffic_monitor;
    import traffic_pkg::*;

    localparam int T_MIN_GREEN  = 8;
    localparam int T_MIN_YELLOW = 3;
    localparam int T_MIN_WALK   = 6;
    localparam int T_MAX_DWELL  = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic [2:0] LA;
    logic [2:0] LB;
    logic       RA;
    logic       RB;
    logic       ERR;
    logic [2:0] fault;

    always #5 clk = ~clk;

    traffic_monitor dut (
        .clk(clk), .reset(reset), .LA(LA), .LB(LB), .RA(RA), .RB(RB),
        .clr(clr), .ERR(ERR), .fault(fault)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Reference model: full sample history since reset, plus index of the last clr sample.
    logic [2:0] h_la[$];
    logic [2:0] h_lb[$];
    logic       h_ra[$];
    logic       h_rb[$];
    int         h_base;
    logic       m_err;
    logic [2:0] m_fault;

    logic [2:0] ph_la [7];
    logic [2:0] ph_lb [7];
    logic       ph_w  [7];
    int         ph_min[7];

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %b, want %b", phase, tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %0d, want %0d", phase, tag, obs, exp);
        end
    endtask

    function automatic bit same_at(input int which, input int a, input int b);
        case (which)
            0: return h_la[a] == h_la[b];
            1: return h_lb[a] == h_lb[b];
            2: return h_ra[a] == h_ra[b];
            default: return (h_la[a] == h_la[b]) && (h_lb[a] == h_lb[b])
                            && (h_ra[a] == h_ra[b]) && (h_rb[a] == h_rb[b]);
        endcase
    endfunction

    // How many consecutive samples up to and including j held the same value (not looking past the last clr).
    function automatic int run_len(input int which, input int j);
        int k;
        k = 0;
        for (int i = j; i >= h_base; i--) begin
            if (!same_at(which, i, j)) break;
            k++;
        end
        return (k > 255) ? 255 : k;
    endfunction

    function automatic bit bad_move(input logic [2:0] p, input logic [2:0] c);
        if (p == c) return 1'b0;
        if ((c == GREEN) && !(p inside {RED_A, RED_B, RED_CLEAR, RED_WALK})) return 1'b1;
        if ((p == GREEN) && (c != YELLOW)) return 1'b1;
        if ((p == YELLOW) && !(c inside {RED_CLEAR, RED_A, RED_B})) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit short_leave(input logic [2:0] p, input logic [2:0] c, input int d);
        if (p == c) return 1'b0;
        if (p == GREEN) return d < T_MIN_GREEN;
        if (p == YELLOW) return d < T_MIN_YELLOW;
        return 1'b0;
    endfunction

    task automatic model_reset();
        h_la.delete();
        h_lb.delete();
        h_ra.delete();
        h_rb.delete();
        h_base  = 0;
        m_err   = 1'b0;
        m_fault = 3'd0;
    endtask

    task automatic model_edge(input logic [2:0] la, input logic [2:0] lb, input logic ra, input logic rb,
                              input logic c);
        int n;
        bit armed;
        bit hit[7];
        h_la.push_back(la);
        h_lb.push_back(lb);
        h_ra.push_back(ra);
        h_rb.push_back(rb);
        n = h_la.size() - 1;
        if (c) begin
            m_err   = 1'b0;
            m_fault = 3'd0;
            h_base  = n;
            return;
        end
        armed = 1'b0;
        for (int i = h_base + 1; i < n; i++)
            if ((h_la[i] != h_la[i-1]) || (h_lb[i] != h_lb[i-1])) armed = 1'b1;
        hit = '{default: 1'b0};
        hit[1] = (la inside {GREEN, YELLOW}) && (lb inside {GREEN, YELLOW});
        hit[2] = ((ra || rb) && !((la == RED_WALK) && (lb == RED_WALK))) || (ra != rb);
        hit[3] = (la == 3'b001) || (lb == 3'b001) || ((la == DARK) != (lb == DARK));
        if (armed) begin
            hit[4] = bad_move(h_la[n-1], la) || bad_move(h_lb[n-1], lb);
            hit[5] = short_leave(h_la[n-1], la, run_len(0, n-1))
                     || short_leave(h_lb[n-1], lb, run_len(1, n-1))
                     || (h_ra[n-1] && !ra && (run_len(2, n-1) < T_MIN_WALK));
            hit[6] = !((la == DARK) && (lb == DARK)) && (run_len(3, n) >= T_MAX_DWELL);
        end
        if (!m_err) begin
            for (int k = 1; k <= 6; k++) begin
                if (hit[k]) begin
                    m_err   = 1'b1;
                    m_fault = 3'(k);
                    break;
                end
            end
        end
    endtask

    task automatic step(input logic [2:0] la, input logic [2:0] lb, input logic ra, input logic rb,
                        input logic c);
        LA  = la;
        LB  = lb;
        RA  = ra;
        RB  = rb;
        clr = c;
        @(posedge clk);
        model_edge(la, lb, ra, rb, c);
        #1;
        check1("err_vs_model", ERR, m_err);
        check3("fault_vs_model", fault, m_fault);
    endtask

    task automatic hold(input logic [2:0] la, input logic [2:0] lb, input logic ra, input logic rb,
                        input int n);
        for (int i = 0; i < n; i++) step(la, lb, ra, rb, 1'b0);
    endtask

    // Asserted between edges; outputs must clear before any further edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check1("rst_err", ERR, 1'b0);
        check3("rst_fault", fault, 3'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic legal_cycle();
        hold(GREEN,     RED_A,     1'b0, 1'b0, 8);
        hold(YELLOW,    RED_B,     1'b0, 1'b0, 3);
        hold(RED_CLEAR, RED_B,     1'b0, 1'b0, 3);
        hold(RED_A,     GREEN,     1'b0, 1'b0, 8);
        hold(RED_B,     YELLOW,    1'b0, 1'b0, 3);
        hold(RED_B,     RED_CLEAR, 1'b0, 1'b0, 3);
        hold(RED_WALK,  RED_WALK,  1'b1, 1'b1, 6);
    endtask

    int         ph;
    int         len;
    int         pick;
    logic [2:0] rla;
    logic [2:0] rlb;
    logic       rra;
    logic       rrb;

    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        LA    = DARK;
        LB    = DARK;
        RA    = 1'b0;
        RB    = 1'b0;
        ph_la  = '{GREEN, YELLOW, RED_CLEAR, RED_A, RED_B, RED_B, RED_WALK};
        ph_lb  = '{RED_A, RED_B, RED_B, GREEN, YELLOW, RED_CLEAR, RED_WALK};
        ph_w   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ph_min = '{8, 3, 3, 8, 3, 3, 6};

        phase = "reset";
        do_reset();

        phase = "legal";
        repeat (7) legal_cycle();
        check1("legal_no_err", ERR, 1'b0);

        phase = "conflict";
        step(GREEN, YELLOW, 1'b0, 1'b0, 1'b0);
        check1("conflict_err", ERR, 1'b1);
        check3("conflict_code", fault, 3'd1);
        hold(GREEN, RED_A, 1'b0, 1'b0, 4);
        check1("conflict_held_err", ERR, 1'b1);
        check3("conflict_held_code", fault, 3'd1);
        step(GREEN, RED_A, 1'b0, 1'b0, 1'b1);
        check1("clr_err", ERR, 1'b0);
        check3("clr_code", fault, 3'd0);
        step(GREEN, RED_A, 1'b0, 1'b0, 1'b0);
        check1("after_clr_err", ERR, 1'b0);

        phase = "short_yellow";
        do_reset();
        hold(RED_CLEAR, RED_B, 1'b0, 1'b0, 2);
        hold(GREEN,     RED_B, 1'b0, 1'b0, 8);
        hold(YELLOW,    RED_B, 1'b0, 1'b0, 2);
        step(RED_CLEAR, RED_B, 1'b0, 1'b0, 1'b0);
        check3("yellow2_code", fault, 3'd5);
        step(RED_CLEAR, RED_B, 1'b0, 1'b0, 1'b1);
        hold(GREEN,     RED_B, 1'b0, 1'b0, 8);
        hold(YELLOW,    RED_B, 1'b0, 1'b0, 3);
        step(RED_CLEAR, RED_B, 1'b0, 1'b0, 1'b0);
        check1("yellow3_err", ERR, 1'b0);
        check3("yellow3_code", fault, 3'd0);

        phase = "simultaneous";
        step(GREEN, GREEN, 1'b1, 1'b0, 1'b0);
        check1("simul_err", ERR, 1'b1);
        check3("simul_code", fault, 3'd1);

        phase = "stall";
        do_reset();
        hold(RED_B, RED_CLEAR, 1'b0, 1'b0, 100);
        check1("unarmed_no_stall", ERR, 1'b0);
        hold(RED_A, GREEN, 1'b0, 1'b0, 63);
        check1("stall_63_err", ERR, 1'b0);
        step(RED_A, GREEN, 1'b0, 1'b0, 1'b0);
        check1("stall_64_err", ERR, 1'b1);
        check3("stall_64_code", fault, 3'd6);

        phase = "async_reset";
        do_reset();
        hold(RED_B, RED_CLEAR, 1'b0, 1'b0, 3);
        hold(RED_A, GREEN,     1'b0, 1'b0, 8);
        step(RED_A, RED_A, 1'b0, 1'b0, 1'b0);
        check3("bad_seq_code", fault, 3'd4);
        do_reset();

        phase = "random";
        for (int r = 0; r < 4; r++) begin
            do_reset();
            ph = 6;
            for (int s = 0; s < 60; s++) begin
                pick = int'($urandom_range(0, 9));
                if (pick < 7) begin
                    ph  = (ph + 1) % 7;
                    rla = ph_la[ph];
                    rlb = ph_lb[ph];
                    rra = ph_w[ph];
                    rrb = ph_w[ph];
                    len = int'($urandom_range(ph_min[ph] + 2, ph_min[ph] - 1));
                end else if (pick < 9) begin
                    rla = 3'($urandom_range(0, 7));
                    rlb = 3'($urandom_range(0, 7));
                    rra = 1'($urandom_range(0, 1));
                    rrb = 1'($urandom_range(0, 1));
                    len = int'($urandom_range(1, 4));
                end else begin
                    rla = ph_la[ph];
                    rlb = ph_lb[ph];
                    rra = ph_w[ph];
                    rrb = ph_w[ph];
                    len = int'($urandom_range(60, 70));
                end
                hold(rla, rlb, rra, rrb, len);
                if ($urandom_range(0, 7) == 0) step(rla, rlb, rra, rrb, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
